// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pooling over a raster-ordered, valid-qualified sample stream.
// A pair register forms horizontal maxima, and a half-row line buffer holds the even-row maxima.
module maxpool2x2_stream #(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     pool_valid,
  output logic signed [DATA_W-1:0] pool_data,
  output logic                     frame_done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int HALF_H = IMG_H / 2;
  localparam int HW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int VW     = (HALF_H > 1) ? $clog2(HALF_H) : 1;

  // The column is {col_pair, col_odd} and the row is {row_pair, row_odd}.
  // col_pair indexes the line buffer directly.
  logic                     col_odd;
  logic [HW-1:0]            col_pair;
  logic                     row_odd;
  logic [VW-1:0]            row_pair;
  logic signed [DATA_W-1:0] pair_reg;
  logic signed [DATA_W-1:0] linebuf [HALF_W];

  logic                     last_col;
  logic                     last_row;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] win_max;

  assign last_col = col_odd && (col_pair == HW'(HALF_W - 1));
  assign last_row = row_odd && (row_pair == VW'(HALF_H - 1));
  assign hmax     = (in_data > pair_reg) ? in_data : pair_reg;
  assign lb_rd    = linebuf[col_pair];
  assign win_max  = (lb_rd > hmax) ? lb_rd : hmax;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_odd    <= 1'b0;
      col_pair   <= '0;
      row_odd    <= 1'b0;
      row_pair   <= '0;
      pair_reg   <= '0;
      pool_valid <= 1'b0;
      pool_data  <= '0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        col_odd <= ~col_odd;
        if (!col_odd) begin
          pair_reg <= in_data;
        end else begin
          if (row_odd) begin
            pool_valid <= 1'b1;
            pool_data  <= win_max;
            frame_done <= last_col && last_row;
          end
          if (last_col) begin
            col_pair <= '0;
            row_odd  <= ~row_odd;
            if (row_odd) begin
              row_pair <= last_row ? '0 : row_pair + VW'(1);
            end
          end else begin
            col_pair <= col_pair + HW'(1);
          end
        end
      end
    end
  end

  // The line buffer has no reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (in_valid && col_odd && !row_odd) begin
      linebuf[col_pair] <= hmax;
    end
  end

endmodule
